fetch_buffer: RTL and testbench

- Instruction prefetch queue between program memory and the fetch/decode boundary of the 5-stage RV32 pipeline.
- Issues sequential word fetches over a request/grant/response handshake, which tolerates multi-cycle memory.
- Holds up to DEPTH fetched instructions with their PCs and presents one per cycle as {command, now_pc}.
- Discards all buffered and in-flight instructions on a PC redirect from execute/memory/hazard logic.

---
 rtl/fetch_buffer_if.sv | 25 ++
 rtl/fetch_buffer.sv | 181 ++++++++++++++++++
 tb/tb_fetch_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_if.sv
// Program-memory fetch port: request/grant address phase followed by a single rvalid data phase.
// The fetch buffer is the master; program memory (or its model) is the slave.
interface fetch_buffer_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue for the RV32 fetch/decode boundary: sequential word fetches with
// one request in flight, DEPTH buffered {pc, instr} entries, and a flush on PC redirect.
module fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stop,
    input  logic                   wb_pc,
    input  logic [31:0]            wb_pc_data,
    fetch_buffer_if.master         mem,
    output logic [31:0]            command,
    output logic [31:0]            now_pc,
    output logic                   cmd_valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned  PW   = $clog2(DEPTH);
    localparam int unsigned  CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DRAIN
    } state_e;

    state_e        state_q,     state_d;
    logic [31:0]   fetch_pc_q,  fetch_pc_d;
    logic          mem_req_q,   mem_req_d;
    logic [31:0]   mem_addr_q,  mem_addr_d;
    logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0] count_q,     count_d;
    logic [31:0]   command_q,   command_d;
    logic [31:0]   now_pc_q,    now_pc_d;
    logic          cmd_valid_q, cmd_valid_d;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic        push;
    logic        pop;
    logic [31:0] redirect_pc;
    logic        unused_pc_lsbs;

    // Redirect targets are word addresses; the low bits carry no information.
    assign redirect_pc    = {wb_pc_data[31:2], 2'b00};
    assign unused_pc_lsbs = ^wb_pc_data[1:0];

    // mem_addr_q is held through RESP, so it is the PC of the word arriving now.
    assign push = (state_q == RESP) && mem.mem_rvalid && !wb_pc;
    assign pop  = !wb_pc && !stop && (count_q != '0);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        command_d   = command_q;
        now_pc_d    = now_pc_q;
        cmd_valid_d = cmd_valid_q;

        if (wb_pc) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            command_d   = NOP;
            cmd_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + PW'(1);
                command_d   = instr_mem[rd_ptr_q];
                now_pc_d    = pc_mem[rd_ptr_q];
                cmd_valid_d = 1'b1;
            end else if (!stop) begin
                command_d   = NOP;
                cmd_valid_d = 1'b0;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;

        unique case (state_q)
            IDLE: begin
                if (!wb_pc && (count_q < FULL)) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (mem.mem_gnt) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    mem_req_d  = 1'b0;
                    state_d    = wb_pc ? DRAIN : RESP;
                end else if (wb_pc) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            RESP: begin
                if (mem.mem_rvalid) begin
                    if (!wb_pc && (count_d < FULL)) begin
                        state_d    = REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = fetch_pc_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wb_pc) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The orphan completes the drain even if a fresh redirect lands on the same edge.
                if (mem.mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wb_pc) begin
            fetch_pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop sees pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            command_q   <= NOP;
            now_pc_q    <= '0;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            command_q   <= command_d;
            now_pc_q    <= now_pc_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    // NOTE: payload storage is not reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= mem_addr_q;
            instr_mem[wr_ptr_q] <= mem.mem_rdata;
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign command      = command_q;
    assign now_pc       = now_pc_q;
    assign cmd_valid    = cmd_valid_q;
    assign count        = count_q;
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: a memory model answering addr+0x100, and a scoreboard of
// expected {pc, instr} entries pushed at response time and popped when the output register loads.
module tb_fetch_buffer;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stop;
    logic        wb_pc;
    logic [31:0] wb_pc_data;
    logic [31:0] command;
    logic [31:0] now_pc;
    logic        cmd_valid;
    logic [$clog2(DEPTH):0] count;

    fetch_buffer_if mem ();

    fetch_buffer #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC),
        .NOP     (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stop      (stop),
        .wb_pc     (wb_pc),
        .wb_pc_data(wb_pc_data),
        .mem       (mem),
        .command   (command),
        .now_pc    (now_pc),
        .cmd_valid (cmd_valid),
        .count     (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    // Memory model: decisions made on the falling edge, taking effect at the next rising edge.
    int          gnt_delay = 0;
    int          rsp_delay = 0;
    int          wcnt      = 0;
    int          rcnt      = 0;
    logic        m_grant   = 1'b0;
    logic        m_rvalid  = 1'b0;
    logic        pend      = 1'b0;
    logic [31:0] m_addr    = '0;
    logic [31:0] pend_addr = '0;

    initial begin
        mem.mem_gnt    = 1'b0;
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            m_rvalid = 1'b0;
            if (m_grant) begin
                pend      = 1'b1;
                pend_addr = m_addr;
                rcnt      = rsp_delay;
            end
            m_grant = 1'b0;
            if (pend) begin
                if (rcnt == 0) begin
                    m_rvalid = 1'b1;
                    pend     = 1'b0;
                end else begin
                    rcnt--;
                end
            end
            if (mem.mem_req && !pend) begin
                if (wcnt >= gnt_delay) begin
                    m_grant = 1'b1;
                    m_addr  = mem.mem_addr;
                    wcnt    = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            mem.mem_gnt    = m_grant;
            mem.mem_rvalid = m_rvalid;
            mem.mem_rdata  = m_rvalid ? pend_addr + 32'h100 : 32'hDEAD_BEEF;
        end
    end

    // Reference model and scoreboard, updated from the inputs seen at each rising edge.
    entry_t      sb[$];
    int          epoch      = 0;
    int          infl_epoch = 0;
    logic        infl_valid = 1'b0;
    logic [31:0] infl_pc    = '0;
    logic [31:0] exp_fetch  = RESET_PC;
    logic [31:0] exp_cmd    = NOP;
    logic [31:0] exp_pc     = '0;
    logic        exp_vld    = 1'b0;

    initial begin
        logic        e_rst, e_wb, e_stop, e_grant, e_rv;
        logic [31:0] e_tgt, e_gaddr;
        entry_t      ent;
        forever begin
            @(posedge clk);
            e_rst   = rst;
            e_wb    = wb_pc;
            e_tgt   = wb_pc_data;
            e_stop  = stop;
            e_grant = m_grant;
            e_gaddr = m_addr;
            e_rv    = m_rvalid;
            #1;
            if (e_rst) begin
                epoch++;
                sb.delete();
                infl_valid = 1'b0;
                exp_fetch  = RESET_PC;
                exp_cmd    = NOP;
                exp_pc     = '0;
                exp_vld    = 1'b0;
                check("rst_req", 32'(mem.mem_req), 32'd0);
                check("rst_addr", mem.mem_addr, RESET_PC);
            end else begin
                if (e_wb) begin
                    sb.delete();
                    exp_cmd = NOP;
                    exp_vld = 1'b0;
                end else if (!e_stop) begin
                    if (sb.size() > 0) begin
                        ent     = sb.pop_front();
                        exp_cmd = ent.instr;
                        exp_pc  = ent.pc;
                        exp_vld = 1'b1;
                    end else begin
                        exp_cmd = NOP;
                        exp_vld = 1'b0;
                    end
                end
                if (e_rv && infl_valid) begin
                    if (infl_epoch == epoch && !e_wb) begin
                        ent.pc    = infl_pc;
                        ent.instr = infl_pc + 32'h100;
                        sb.push_back(ent);
                    end
                    infl_valid = 1'b0;
                end
                if (e_grant) begin
                    check("gnt_addr", e_gaddr, exp_fetch);
                    infl_valid = 1'b1;
                    infl_pc    = exp_fetch;
                    infl_epoch = epoch;
                    exp_fetch  = exp_fetch + 32'd4;
                end
                if (e_wb) begin
                    epoch++;
                    exp_fetch = {e_tgt[31:2], 2'b00};
                end
            end
            check("count", 32'(count), 32'(sb.size()));
            check("cmd_valid", 32'(cmd_valid), 32'(exp_vld));
            check("command", command, exp_cmd);
            check("now_pc", now_pc, exp_pc);
            if (mem.mem_req) check("req_addr", mem.mem_addr, exp_fetch);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (cmd_valid) return;
            cyc(1);
        end
        check(tag, 32'(cmd_valid), 32'd1);
    endtask

    task automatic wait_count(input string tag, input int n, input int max);
        for (int i = 0; i < max; i++) begin
            if (int'(count) == n) return;
            cyc(1);
        end
        check(tag, 32'(count), 32'(n));
    endtask

    task automatic wait_pend(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (pend) return;
            cyc(1);
        end
        check(tag, 32'(pend), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        stop       = 1'b0;
        wb_pc      = 1'b0;
        wb_pc_data = '0;
        cyc(3);
        check("rst_count", 32'(count), 32'd0);
        check("rst_cmd", command, NOP);
        check("rst_vld", 32'(cmd_valid), 32'd0);
        check("rst_pc", now_pc, 32'd0);
        rst = 1'b0;

        // Zero-wait memory: first word out of reset.
        wait_valid("first_valid_timeout", 30);
        check("first_cmd", command, 32'h100);
        check("first_pc", now_pc, RESET_PC);

        // Stall from the first valid output: queue fills, requests stop, then drains back to back.
        stop = 1'b1;
        wait_count("fill_timeout", DEPTH, 60);
        cyc(4);
        check("full_count", 32'(count), DEPTH);
        check("full_noreq", 32'(mem.mem_req), 32'd0);
        stop = 1'b0;
        cyc(1);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_vld", 32'(cmd_valid), 32'd1);
            check("drain_pc", now_pc, 32'h4 + 32'(4 * i));
            cyc(1);
        end
        cyc(4);

        // Redirect while a response is outstanding: the orphan must be drained, not delivered.
        rsp_delay = 2;
        wait_pend("resp_timeout", 40);
        wb_pc      = 1'b1;
        wb_pc_data = 32'h203;
        cyc(1);
        wb_pc = 1'b0;
        check("redir_count", 32'(count), 32'd0);
        check("redir_vld", 32'(cmd_valid), 32'd0);
        wait_valid("redir_valid_timeout", 40);
        check("redir_cmd", command, 32'h300);
        check("redir_pc", now_pc, 32'h200);
        rsp_delay = 0;
        cyc(4);

        // Redirect with stop held and the queue full: flush wins over the stall.
        stop = 1'b1;
        wait_count("fill2_timeout", DEPTH, 60);
        cyc(2);
        wb_pc      = 1'b1;
        wb_pc_data = 32'h400;
        cyc(1);
        wb_pc = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_cmd", command, NOP);
        check("flush_vld", 32'(cmd_valid), 32'd0);
        check("flush_pc", now_pc, exp_pc);
        stop = 1'b0;
        wait_valid("flush_valid_timeout", 40);
        check("flush_next_cmd", command, 32'h500);
        check("flush_next_pc", now_pc, 32'h400);

        // Slow grant: the address must hold through every waiting REQ cycle.
        gnt_delay = 3;
        cyc(40);
        gnt_delay = 0;

        // Reset while a response is outstanding; the late response must be ignored.
        rsp_delay = 1;
        wait_pend("resp2_timeout", 40);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rst2_count", 32'(count), 32'd0);
        check("rst2_vld", 32'(cmd_valid), 32'd0);
        check("rst2_pc", now_pc, 32'd0);
        rsp_delay = 0;
        wait_valid("rst2_valid_timeout", 40);
        check("rst2_first_pc", now_pc, RESET_PC);
        check("rst2_first_cmd", command, RESET_PC + 32'h100);

        // Misaligned target near the top of the address space: fetch_pc wraps to zero.
        wb_pc      = 1'b1;
        wb_pc_data = 32'hFFFF_FFFA;
        cyc(1);
        wb_pc = 1'b0;
        wait_valid("wrap_valid_timeout", 40);
        check("wrap_pc", now_pc, 32'hFFFF_FFF8);
        check("wrap_cmd", command, 32'h0000_00F8);
        cyc(16);

        // Mixed traffic: random stalls, memory latencies and redirects.
        for (int i = 0; i < 200; i++) begin
            stop = ($urandom_range(0, 3) == 0);
            if (i % 10 == 0) begin
                gnt_delay = $urandom_range(0, 2);
                rsp_delay = $urandom_range(0, 2);
            end
            if ($urandom_range(0, 29) == 0) begin
                wb_pc      = 1'b1;
                wb_pc_data = $urandom;
            end else begin
                wb_pc = 1'b0;
            end
            cyc(1);
        end
        stop  = 1'b0;
        wb_pc = 1'b0;
        cyc(10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
